// File: rtl/conv3x3_stream.sv
//==============================================================================
// Module      : conv3x3_stream
// Description : Streaming 3x3 valid-only convolution with line buffers,
//               two-stage multiply/accumulate, bias, saturation and
//               optional ReLU, delivered over a valid/ready interface.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv3x3_stream #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int RELU   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9*COEF_W-1:0]   weight_in,
  input  logic [OUT_W-1:0]      bias_in,
  input  logic                  weight_load,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [OUT_W-1:0]      conv_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int ACC_W  = DATA_W + COEF_W + 5;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic                     en, accept, win_ok, win_last, last_taken;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     busy_q, busy_d;
  logic signed [COEF_W-1:0] w_q [9];
  logic signed [OUT_W-1:0]  bias_q;
  logic [DATA_W-1:0]        lb1_q [IMG_W];
  logic [DATA_W-1:0]        lb2_q [IMG_W];
  logic [DATA_W-1:0]        win_q [9];
  logic                     s0_valid_q, s0_last_q;
  logic                     s1_valid_q, s1_last_q;
  logic signed [PROD_W-1:0] w_prod [9];
  logic signed [PROD_W-1:0] prod_q [9];
  logic signed [ACC_W-1:0]  acc, sat;
  logic [OUT_W-1:0]         res_d;
  logic [OUT_W-1:0]         conv_out_q;
  logic                     out_valid_q, out_last_q;

  // The whole pipeline advances together; a held output freezes everything.
  assign en         = ~out_valid_q | out_ready;
  assign accept     = pix_valid & en;
  assign win_ok     = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign win_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign last_taken = out_valid_q & out_last_q & out_ready;

  assign pix_ready = en;
  assign conv_out  = conv_out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

  // Raster position and frame-activity bookkeeping for the next pixel.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    busy_d = busy_q;
    if (accept) begin
      busy_d = 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (last_taken) begin
      busy_d = 1'b0;
    end
  end

  // Coefficients may only change between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) w_q[k] <= '0;
      bias_q <= '0;
    end else if (weight_load && !busy_q) begin
      for (int k = 0; k < 9; k++) w_q[k] <= weight_in[(8-k)*COEF_W +: COEF_W];
      bias_q <= bias_in;
    end
  end

  // Line buffers and the 3x3 window carry data only; they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= pix_in;
      lb2_q[col_q] <= lb1_q[col_q];
      for (int r = 0; r < 3; r++) begin
        win_q[r*3+0] <= win_q[r*3+1];
        win_q[r*3+1] <= win_q[r*3+2];
      end
      win_q[2] <= lb2_q[col_q];
      win_q[5] <= lb1_q[col_q];
      win_q[8] <= pix_in;
    end
  end

  // Pixels are unsigned, so they get a zero sign bit before the signed multiply.
  for (genvar k = 0; k < 9; k++) begin : g_prod
    assign w_prod[k] = PROD_W'($signed({1'b0, win_q[k]})) * PROD_W'(w_q[k]);
  end

  // Sum, clamp to the output range and optionally rectify.
  always_comb begin
    acc = ACC_W'(bias_q);
    for (int k = 0; k < 9; k++) acc = acc + ACC_W'(prod_q[k]);
    if (acc > SAT_MAX)      sat = SAT_MAX;
    else if (acc < SAT_MIN) sat = SAT_MIN;
    else                    sat = acc;
    res_d = sat[OUT_W-1:0];
    if (RELU != 0 && sat[ACC_W-1]) res_d = '0;
  end

  // Counters, window-valid tag, product and result stages, all gated by en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      conv_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      busy_q <= busy_d;
      if (en) begin
        s0_valid_q  <= accept & win_ok;
        s0_last_q   <= accept & win_last;
        s1_valid_q  <= s0_valid_q;
        s1_last_q   <= s0_last_q;
        for (int k = 0; k < 9; k++) prod_q[k] <= w_prod[k];
        conv_out_q  <= res_d;
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_last_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
//==============================================================================
// Module      : tb_conv3x3_stream
// Description : Scoreboard bench for conv3x3_stream; one ReLU and one
//               pass-through instance share all stimulus.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv3x3_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] weight_in = '0;
  logic [15:0] bias_in = '0;
  logic        weight_load = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        pix_ready1, out_valid1, out_last1, busy1;
  logic [15:0] conv_out1;
  logic        pix_ready0, out_valid0, out_last0, busy0;
  logic [15:0] conv_out0;

  always #5 clk = ~clk;

  conv3x3_stream #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .COEF_W(8), .OUT_W(16), .RELU(1)) u_dut1 (
    .clk(clk), .rst(rst), .weight_in(weight_in), .bias_in(bias_in),
    .weight_load(weight_load), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready1), .conv_out(conv_out1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_last(out_last1), .busy(busy1));

  conv3x3_stream #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .COEF_W(8), .OUT_W(16), .RELU(0)) u_dut0 (
    .clk(clk), .rst(rst), .weight_in(weight_in), .bias_in(bias_in),
    .weight_load(weight_load), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready0), .conv_out(conv_out0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_last(out_last0), .busy(busy0));

  typedef struct packed {
    logic [15:0] e1;
    logic [15:0] e0;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   busy_chk = 1'b0;

  localparam int RAMP [9] = '{54, 63, 72, 99, 108, 117, 144, 153, 162};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] e1, input logic [15:0] e0, input logic last);
    exp_t t;
    t.e1 = e1;
    t.e0 = e0;
    t.last = last;
    sb.push_back(t);
  endtask

  task automatic push_const(input logic [15:0] e1, input logic [15:0] e0);
    for (int i = 0; i < 9; i++) push_exp(e1, e0, i == 8);
  endtask

  task automatic push_ramp(input int mult);
    for (int i = 0; i < 9; i++) push_exp(16'(RAMP[i] * mult), 16'(RAMP[i] * mult), i == 8);
  endtask

  task automatic load_w(input logic [7:0] w, input logic [15:0] b);
    weight_in   = {9{w}};
    bias_in     = b;
    weight_load = 1'b1;
    @(posedge clk); #1;
    weight_load = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] p);
    bit ok;
    ok        = 1'b0;
    pix_valid = 1'b1;
    pix_in    = p;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = pix_ready1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL pix_accept: got timeout expected acceptance at %0t", $time);
    end
    pix_valid = 1'b0;
  endtask

  // ramp=1 sends 0..24, else 25 copies of cval; wl_idx marks the pixel that
  // carries a weight_load of wl_val (-1 for none).
  task automatic send_frame(input bit ramp, input logic [7:0] cval, input bit gaps,
                            input int wl_idx, input logic [7:0] wl_val);
    for (int i = 0; i < 25; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      if (i == wl_idx) begin
        weight_in   = {9{wl_val}};
        weight_load = 1'b1;
      end
      send_pix(ramp ? 8'(i) : cval);
      weight_load = 1'b0;
      if (i == 0) chk("busy_first_pixel", {31'd0, busy1}, 32'd1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0 && !busy1) break;
      @(posedge clk); #1;
    end
    chk("drain_done", {31'd0, (sb.size() == 0 && !busy1)}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic stall_proc();
    logic [15:0] held;
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(posedge clk); #1;
      seen = out_valid1;
    end
    chk("stall_seen_valid", {31'd0, seen}, 32'd1);
    out_ready = 1'b0;
    held = conv_out1;
    chk("stall_first_value", {16'd0, held}, 32'd54);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold_out", {16'd0, conv_out1}, {16'd0, held});
      chk("stall_pix_ready", {31'd0, pix_ready1}, 32'd0);
      chk("stall_valid_held", {31'd0, out_valid1}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  // Monitor: pop and compare each accepted result from both instances.
  always @(negedge clk) begin
    if (busy_chk) begin
      chk("busy_after_last", {31'd0, busy1}, 32'd0);
      chk("busy0_after_last", {31'd0, busy0}, 32'd0);
      busy_chk = 1'b0;
    end
    if (!rst && out_valid1 && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h expected none at %0t", conv_out1, $time);
      end else begin
        exp_t t;
        t = sb.pop_front();
        chk("conv_out_relu1", {16'd0, conv_out1}, {16'd0, t.e1});
        chk("conv_out_relu0", {16'd0, conv_out0}, {16'd0, t.e0});
        chk("out_last", {31'd0, out_last1}, {31'd0, t.last});
        chk("valid_relu0", {31'd0, out_valid0}, 32'd1);
        if (t.last) busy_chk = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_out_last", {31'd0, out_last1}, 32'd0);
    chk("rst_conv_out", {16'd0, conv_out1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_pix_ready", {31'd0, pix_ready1}, 32'd1);
    @(posedge clk); #1;

    // Unit weights on a flat frame.
    load_w(8'h01, 16'd0);
    push_const(16'd9, 16'd9);
    send_frame(1'b0, 8'd1, 1'b0, -1, 8'd0);
    drain();

    // Unit weights on a ramp.
    push_ramp(1);
    send_frame(1'b1, 8'd0, 1'b0, -1, 8'd0);
    drain();

    // Positive saturation.
    load_w(8'h7F, 16'd0);
    push_const(16'h7FFF, 16'h7FFF);
    send_frame(1'b0, 8'd255, 1'b0, -1, 8'd0);
    drain();

    // Negative weights: ReLU clamps, pass-through keeps -9.
    load_w(8'hFF, 16'd0);
    push_const(16'h0000, 16'hFFF7);
    send_frame(1'b0, 8'd1, 1'b0, -1, 8'd0);
    drain();

    // Bias lifts -9 to 11.
    load_w(8'hFF, 16'd20);
    push_const(16'd11, 16'd11);
    send_frame(1'b0, 8'd1, 1'b0, -1, 8'd0);
    drain();

    // Backpressure at the first result.
    load_w(8'h01, 16'd0);
    push_ramp(1);
    fork
      send_frame(1'b1, 8'd0, 1'b0, -1, 8'd0);
      stall_proc();
    join
    drain();

    // Gaps in pixel delivery.
    push_ramp(1);
    send_frame(1'b1, 8'd0, 1'b1, -1, 8'd0);
    drain();

    // weight_load mid-frame is ignored, now and for the following frame.
    push_ramp(1);
    send_frame(1'b1, 8'd0, 1'b0, 5, 8'h02);
    drain();
    push_ramp(1);
    send_frame(1'b1, 8'd0, 1'b0, -1, 8'd0);
    drain();

    // weight_load on the first pixel of a frame is honoured.
    push_ramp(2);
    send_frame(1'b1, 8'd0, 1'b0, 0, 8'h02);
    drain();

    // Reset after 12 pixels, then a clean frame.
    load_w(8'h01, 16'd0);
    for (int i = 0; i < 12; i++) send_pix(8'(i));
    chk("busy_before_rst", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("midrst_busy", {31'd0, busy1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    load_w(8'h01, 16'd0);
    push_ramp(1);
    send_frame(1'b1, 8'd0, 1'b0, -1, 8'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
